rob_commit_unit: RTL and testbench

In-order retirement buffer sitting directly upstream of the architectural register file wrapper. It tracks instructions from allocation to writeback and retires up to `NUM_COMMITS` completed head entries per cycle. Retired entries are driven as registered commit beats (valid, type, architectural destination, value), so the architectural file updates only in program order. A flush input discards all in-flight entries.

---
 rtl/rob_commit_unit.sv | 126 ++++++++++++
 tb/tb_rob_commit_unit.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rob_commit_unit.sv
// In-order retirement buffer: tracks entries from allocation through writeback
// and drives up to NUM_COMMITS registered commit beats per cycle in program order.
module rob_commit_unit #(
  parameter int ROB_DEPTH   = 16,
  parameter int NUM_COMMITS = 2,
  parameter int ARCH_ADDR_W = 5,
  parameter int REG_VAL_W   = 32,
  parameter int TAG_W       = $clog2(ROB_DEPTH)
) (
  input  logic                                     clk,
  input  logic                                     reset,
  input  logic                                     alloc_valid,
  output logic                                     alloc_ready,
  input  logic [1:0]                               alloc_type,
  input  logic [ARCH_ADDR_W-1:0]                   alloc_arch_reg,
  output logic [TAG_W-1:0]                         alloc_tag,
  input  logic                                     wb_valid,
  input  logic [TAG_W-1:0]                         wb_tag,
  input  logic [REG_VAL_W-1:0]                     wb_value,
  input  logic                                     flush,
  output logic [NUM_COMMITS-1:0]                   commit_valid,
  output logic [NUM_COMMITS-1:0][1:0]              commit_type,
  output logic [NUM_COMMITS-1:0][ARCH_ADDR_W-1:0]  commit_arch_reg_addr,
  output logic [NUM_COMMITS-1:0][REG_VAL_W-1:0]    commit_value,
  output logic [TAG_W:0]                           count
);

  localparam int         PTR_W      = TAG_W + 1;
  localparam logic [1:0] TYPE_NO_WB = 2'd2;

  logic [PTR_W-1:0]       head_r;
  logic [PTR_W-1:0]       tail_r;
  logic [ROB_DEPTH-1:0]   busy_r;
  logic [ROB_DEPTH-1:0]   done_r;
  logic [1:0]             type_r  [ROB_DEPTH];
  logic [ARCH_ADDR_W-1:0] arch_r  [ROB_DEPTH];
  logic [REG_VAL_W-1:0]   value_r [ROB_DEPTH];

  logic                   clear_s;
  logic                   full_s;
  logic                   alloc_fire_s;
  logic                   wb_hit_s;
  logic [NUM_COMMITS-1:0] retire_s;
  logic [TAG_W-1:0]       slot_idx_s [NUM_COMMITS];
  logic [PTR_W-1:0]       num_retire_s;
  logic                   chain_s;

  assign clear_s      = reset | flush;
  assign full_s       = (head_r[TAG_W-1:0] == tail_r[TAG_W-1:0]) && (head_r[TAG_W] != tail_r[TAG_W]);
  assign alloc_ready  = !full_s && !reset;
  assign alloc_fire_s = alloc_valid && alloc_ready && !flush;
  // Only busy entries accept a writeback; the entry being allocated is never busy yet.
  assign wb_hit_s     = wb_valid && busy_r[wb_tag] && !clear_s;
  assign alloc_tag    = tail_r[TAG_W-1:0];
  assign count        = tail_r - head_r;

  // Head-slot scan: a slot retires only if it and every older slot are done.
  always_comb begin
    retire_s     = '0;
    num_retire_s = '0;
    chain_s      = 1'b1;
    for (int k = 0; k < NUM_COMMITS; k++) begin
      slot_idx_s[k] = head_r[TAG_W-1:0] + TAG_W'(k);
      chain_s       = chain_s & busy_r[slot_idx_s[k]] & done_r[slot_idx_s[k]];
      retire_s[k]   = chain_s;
      num_retire_s  = num_retire_s + PTR_W'(chain_s);
    end
  end

  // Pointers and per-entry busy/done flags; later assignments take priority.
  always_ff @(posedge clk) begin
    if (clear_s) begin
      head_r <= '0;
      tail_r <= '0;
      busy_r <= '0;
      done_r <= '0;
    end else begin
      if (wb_hit_s) begin
        done_r[wb_tag] <= 1'b1;
      end
      for (int k = 0; k < NUM_COMMITS; k++) begin
        if (retire_s[k]) begin
          busy_r[slot_idx_s[k]] <= 1'b0;
          done_r[slot_idx_s[k]] <= 1'b0;
        end
      end
      if (alloc_fire_s) begin
        busy_r[tail_r[TAG_W-1:0]] <= 1'b1;
        done_r[tail_r[TAG_W-1:0]] <= 1'b0;
        tail_r                    <= tail_r + PTR_W'(1);
      end
      head_r <= head_r + num_retire_s;
    end
  end

  // Entry payload storage; validity is carried entirely by busy/done.
  always_ff @(posedge clk) begin
    if (wb_hit_s) begin
      value_r[wb_tag] <= wb_value;
    end
    if (alloc_fire_s) begin
      type_r[tail_r[TAG_W-1:0]]  <= alloc_type;
      arch_r[tail_r[TAG_W-1:0]]  <= alloc_arch_reg;
      value_r[tail_r[TAG_W-1:0]] <= '0;
    end
  end

  // Registered commit beat; non-retiring slots and no_wb values are forced to zero.
  always_ff @(posedge clk) begin
    if (clear_s) begin
      commit_valid         <= '0;
      commit_type          <= '0;
      commit_arch_reg_addr <= '0;
      commit_value         <= '0;
    end else begin
      for (int k = 0; k < NUM_COMMITS; k++) begin
        commit_valid[k]         <= retire_s[k];
        commit_type[k]          <= retire_s[k] ? type_r[slot_idx_s[k]] : 2'b00;
        commit_arch_reg_addr[k] <= retire_s[k] ? arch_r[slot_idx_s[k]] : '0;
        commit_value[k]         <= (retire_s[k] && (type_r[slot_idx_s[k]] != TYPE_NO_WB)) ?
                                   value_r[slot_idx_s[k]] : '0;
      end
    end
  end

endmodule

// File: tb/tb_rob_commit_unit.sv
// Bench for rob_commit_unit: directed scenarios plus random traffic, checked
// every cycle against a queue-based model of the retirement buffer.
module tb_rob_commit_unit;

  localparam int DEPTH = 16;
  localparam int NC    = 2;
  localparam int AW    = 5;
  localparam int VW    = 32;
  localparam int TW    = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                   reset;
  logic                   alloc_valid;
  logic                   alloc_ready;
  logic [1:0]             alloc_type;
  logic [AW-1:0]          alloc_arch_reg;
  logic [TW-1:0]          alloc_tag;
  logic                   wb_valid;
  logic [TW-1:0]          wb_tag;
  logic [VW-1:0]          wb_value;
  logic                   flush;
  logic [NC-1:0]          commit_valid;
  logic [NC-1:0][1:0]     commit_type;
  logic [NC-1:0][AW-1:0]  commit_arch_reg_addr;
  logic [NC-1:0][VW-1:0]  commit_value;
  logic [TW:0]            count;

  rob_commit_unit #(
    .ROB_DEPTH(DEPTH), .NUM_COMMITS(NC), .ARCH_ADDR_W(AW), .REG_VAL_W(VW), .TAG_W(TW)
  ) dut (
    .clk(clk), .reset(reset),
    .alloc_valid(alloc_valid), .alloc_ready(alloc_ready), .alloc_type(alloc_type),
    .alloc_arch_reg(alloc_arch_reg), .alloc_tag(alloc_tag),
    .wb_valid(wb_valid), .wb_tag(wb_tag), .wb_value(wb_value), .flush(flush),
    .commit_valid(commit_valid), .commit_type(commit_type),
    .commit_arch_reg_addr(commit_arch_reg_addr), .commit_value(commit_value),
    .count(count)
  );

  // Reference model: the buffer is a program-ordered queue of in-flight entries.
  typedef struct {
    int            tag;
    logic [1:0]    typ;
    logic [AW-1:0] arch;
    logic [VW-1:0] val;
    bit            done;
  } ent_t;

  ent_t             q[$];
  int               next_tag;
  logic [NC-1:0]    exp_cv;
  logic [NC*2-1:0]  exp_ct;
  logic [NC*AW-1:0] exp_ca;
  logic [NC*VW-1:0] exp_cvl;
  int               checks;
  int               errors;

  task automatic check_val(input string name, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, obs, exp, $time);
    end
  endtask

  task automatic check_all();
    check_val("alloc_ready", 64'(alloc_ready), 64'(!reset && (q.size() < DEPTH)));
    check_val("alloc_tag", 64'(alloc_tag), 64'(next_tag));
    check_val("count", 64'(count), 64'(q.size()));
    check_val("commit_valid", 64'(commit_valid), 64'(exp_cv));
    check_val("commit_type", 64'(commit_type), 64'(exp_ct));
    check_val("commit_arch", 64'(commit_arch_reg_addr), 64'(exp_ca));
    check_val("commit_value", 64'(commit_value), 64'(exp_cvl));
  endtask

  // One clock edge of the model, using the inputs that were applied this cycle.
  task automatic model_step();
    int n;
    bit rdy;
    ent_t e;
    exp_cv  = '0;
    exp_ct  = '0;
    exp_ca  = '0;
    exp_cvl = '0;
    if (reset || flush) begin
      q.delete();
      next_tag = 0;
    end else begin
      rdy = (q.size() < DEPTH);
      n = 0;
      while (n < NC && n < q.size() && q[n].done) n++;
      for (int k = 0; k < n; k++) begin
        exp_cv[k]           = 1'b1;
        exp_ct[k*2 +: 2]    = q[k].typ;
        exp_ca[k*AW +: AW]  = q[k].arch;
        exp_cvl[k*VW +: VW] = (q[k].typ == 2'd2) ? '0 : q[k].val;
      end
      if (wb_valid) begin
        for (int i = 0; i < q.size(); i++) begin
          if (q[i].tag == int'(wb_tag)) begin
            q[i].done = 1'b1;
            q[i].val  = wb_value;
          end
        end
      end
      for (int k = 0; k < n; k++) void'(q.pop_front());
      if (alloc_valid && rdy) begin
        e.tag  = next_tag;
        e.typ  = alloc_type;
        e.arch = alloc_arch_reg;
        e.val  = '0;
        e.done = 1'b0;
        q.push_back(e);
        next_tag = (next_tag + 1) % DEPTH;
      end
    end
  endtask

  task automatic drive(input logic rst, input logic av, input logic [1:0] at,
                       input logic [AW-1:0] ar, input logic wv, input logic [TW-1:0] wt,
                       input logic [VW-1:0] wval, input logic fl);
    @(negedge clk);
    reset          = rst;
    alloc_valid    = av;
    alloc_type     = at;
    alloc_arch_reg = ar;
    wb_valid       = wv;
    wb_tag         = wt;
    wb_value       = wval;
    flush          = fl;
    #1;
    check_all();
    @(posedge clk);
    model_step();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 2'd0, 5'd0, 1'b0, 4'd0, 32'd0, 1'b0);
  endtask

  task automatic alloc(input logic [1:0] t, input logic [AW-1:0] r);
    drive(1'b0, 1'b1, t, r, 1'b0, 4'd0, 32'd0, 1'b0);
  endtask

  task automatic wb(input logic [TW-1:0] t, input logic [VW-1:0] v);
    drive(1'b0, 1'b0, 2'd0, 5'd0, 1'b1, t, v, 1'b0);
  endtask

  task automatic do_reset();
    drive(1'b1, 1'b1, 2'd0, 5'd0, 1'b0, 4'd0, 32'd0, 1'b0);
  endtask

  initial begin
    int wb_pct;
    logic [TW-1:0] wt;
    checks = 0;
    errors = 0;
    next_tag = 0;
    reset = 1'b1; alloc_valid = 1'b0; alloc_type = 2'd0; alloc_arch_reg = '0;
    wb_valid = 1'b0; wb_tag = '0; wb_value = '0; flush = 1'b0;
    @(posedge clk);
    model_step();

    // Reset state, then two entries completing youngest-first retire together.
    do_reset();
    do_reset();
    alloc(2'd0, 5'd3);
    alloc(2'd0, 5'd4);
    wb(4'd1, 32'h22);
    wb(4'd0, 32'h11);
    idle(3);

    // Out-of-order completion.
    do_reset();
    for (int i = 0; i < 3; i++) alloc(2'd0, 5'(i + 8));
    wb(4'd2, 32'hc2);
    wb(4'd1, 32'hc1);
    idle(2);
    wb(4'd0, 32'hc0);
    idle(4);

    // Fill, overflow attempt, drain in order, then refill across the wrap.
    do_reset();
    for (int i = 0; i < DEPTH + 1; i++) alloc(2'd0, 5'(i));
    for (int i = 0; i < DEPTH; i++) wb(4'(i), 32'h100 + 32'(i));
    idle(10);
    for (int i = 0; i < DEPTH; i++) alloc(2'd0, 5'(i + 16));
    for (int i = DEPTH - 1; i >= 0; i--) wb(4'(i), 32'h200 + 32'(i));
    idle(10);

    // Full buffer retiring its head while alloc is requested; alloc/wb same tag.
    do_reset();
    for (int i = 0; i < DEPTH; i++) alloc(2'd0, 5'(i));
    wb(4'd1, 32'h31);
    wb(4'd0, 32'h30);
    alloc(2'd0, 5'd20);
    alloc(2'd0, 5'd21);
    idle(2);
    for (int i = 2; i < DEPTH; i++) wb(4'(i), 32'h40 + 32'(i));
    idle(8);
    drive(1'b0, 1'b1, 2'd0, 5'd9, 1'b1, next_tag[TW-1:0], 32'hdead, 1'b0);
    idle(3);

    // Flush while two done head entries are about to retire.
    do_reset();
    for (int i = 0; i < 5; i++) alloc(2'd0, 5'(i + 1));
    wb(4'd1, 32'h51);
    wb(4'd0, 32'h50);
    drive(1'b0, 1'b1, 2'd0, 5'd7, 1'b1, 4'd2, 32'h52, 1'b1);
    idle(1);
    alloc(2'd0, 5'd6);
    idle(2);

    // Store and no_wb types.
    do_reset();
    alloc(2'd1, 5'd7);
    alloc(2'd2, 5'd8);
    wb(4'd0, 32'h77);
    wb(4'd1, 32'h88);
    idle(3);

    // Random traffic with alternating completion pressure.
    wb_pct = 20;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (cyc % 150 == 0) wb_pct = (wb_pct == 20) ? 85 : 20;
      if (q.size() > 0 && $urandom_range(0, 3) != 0)
        wt = q[$urandom_range(0, q.size() - 1)].tag[TW-1:0];
      else
        wt = 4'($urandom_range(0, DEPTH - 1));
      drive(($urandom_range(0, 299) == 0),
            ($urandom_range(0, 2) != 0),
            2'($urandom_range(0, 2)),
            5'($urandom_range(0, 31)),
            ($urandom_range(0, 99) < wb_pct),
            wt,
            $urandom,
            ($urandom_range(0, 99) == 0));
    end
    idle(4);

    @(negedge clk);
    #1;
    check_all();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
